slice_stage_sequencer: RTL and testbench

Parametrised per-slice control sequencer for the ProRes encoder datapath. It sits between the slice scheduler and the DCT → DC VLC → AC VLC chain. On each accepted `slice_start` it runs one slice timeline, sized by that slice's block count, and drives the reset, output-enable and flush windows plus the coefficient-index counters of both VLC stages. Compared with the fixed sequencer it adds explicit idle/run/done control, a per-slice latched block count, configurable stage latencies, and start/parameter error reporting.

---
 rtl/slice_stage_sequencer_if.sv | 34 +++
 rtl/slice_stage_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_slice_stage_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/slice_stage_sequencer_if.sv
// rtl/slice_stage_sequencer_if.sv - scheduler-facing and stage-control bundle for slice_stage_sequencer
interface slice_stage_sequencer_if #(
    parameter int BLK_W = 8,
    parameter int CNT_W = 16
) ();
    logic             slice_start;
    logic [BLK_W-1:0] block_num;
    logic             busy;
    logic             done;
    logic             start_err;
    logic             param_err;
    logic [CNT_W-1:0] sequence_counter;
    logic             dc_vlc_reset_n;
    logic             dc_vlc_output_enable;
    logic [CNT_W-1:0] dc_vlc_counter;
    logic             ac_vlc_reset_n;
    logic             ac_vlc_output_enable;
    logic             ac_vlc_output_flush;
    logic [CNT_W-1:0] ac_vlc_counter;

    modport master (
        output slice_start, block_num,
        input  busy, done, start_err, param_err, sequence_counter,
        input  dc_vlc_reset_n, dc_vlc_output_enable, dc_vlc_counter,
        input  ac_vlc_reset_n, ac_vlc_output_enable, ac_vlc_output_flush, ac_vlc_counter
    );

    modport slave (
        input  slice_start, block_num,
        output busy, done, start_err, param_err, sequence_counter,
        output dc_vlc_reset_n, dc_vlc_output_enable, dc_vlc_counter,
        output ac_vlc_reset_n, ac_vlc_output_enable, ac_vlc_output_flush, ac_vlc_counter
    );
endinterface

// File: rtl/slice_stage_sequencer.sv
// rtl/slice_stage_sequencer.sv - per-slice DCT/DC VLC/AC VLC control sequencer
// Optional one-entry start queue: define SEQ_START_QUEUE_EN.
module slice_stage_sequencer #(
    parameter int DCT_LATENCY    = 12,
    parameter int DC_VLC_LATENCY = 44,
    parameter int BLK_W          = 8,
    parameter int MAX_BLOCKS     = 8,
    parameter int CNT_W          = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    slice_stage_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] DCT_L = CNT_W'(DCT_LATENCY);
    localparam logic [CNT_W-1:0] DCV_L = CNT_W'(DC_VLC_LATENCY);
    localparam logic [CNT_W-1:0] K63   = CNT_W'(63);
    localparam logic [BLK_W-1:0] MAX_N = BLK_W'(MAX_BLOCKS);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BLK_W-1:0] n_q, n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             start_err_q, start_err_d;
    logic             param_err_q, param_err_d;
    logic             dc_rst_q, dc_rst_d;
    logic             dc_oe_q, dc_oe_d;
    logic             ac_rst_q, ac_rst_d;
    logic             ac_oe_q, ac_oe_d;
    logic             flush_q, flush_d;
`ifdef SEQ_START_QUEUE_EN
    logic             pend_q, pend_d;
    logic [BLK_W-1:0] pend_n_q, pend_n_d;
`endif

    logic             start_legal;
    logic [CNT_W-1:0] n_ext_q, t1_q, t2_q, e_q;
    logic [CNT_W-1:0] n_ext_d, t1_d, t2_d, ac_end_d;
    logic             run_d;

    assign start_legal = (bus.block_num != '0) && (bus.block_num <= MAX_N);

    // Window bases for the slice currently held, and for the one about to be shown.
    assign n_ext_q  = CNT_W'(n_q);
    assign t1_q     = DCT_L + n_ext_q;
    assign t2_q     = t1_q + DCV_L;
    assign e_q      = t2_q + K63 * n_ext_q + CNT_W'(8);
    assign n_ext_d  = CNT_W'(n_d);
    assign t1_d     = DCT_L + n_ext_d;
    assign t2_d     = t1_d + DCV_L;
    assign ac_end_d = t2_d + K63 * n_ext_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        start_err_d = 1'b0;
        param_err_d = 1'b0;
`ifdef SEQ_START_QUEUE_EN
        pend_d      = pend_q;
        pend_n_d    = pend_n_q;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.slice_start) begin
                    if (start_legal) begin
                        state_d = RUN;
                        n_d     = bus.block_num;
                    end else begin
                        param_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (cnt_q == e_q) state_d = DONE;
                else              cnt_d   = cnt_q + CNT_W'(1);
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && bus.slice_start) begin
`ifdef SEQ_START_QUEUE_EN
            if (!start_legal) begin
                param_err_d = 1'b1;
            end else if (!pend_q) begin
                pend_d   = 1'b1;
                pend_n_d = bus.block_num;
            end else begin
                start_err_d = 1'b1;
            end
`else
            start_err_d = 1'b1;
`endif
        end

`ifdef SEQ_START_QUEUE_EN
        // A slot filled before or during DONE launches straight into RUN.
        if (state_q == DONE && pend_d) begin
            state_d = RUN;
            n_d     = pend_n_d;
            pend_d  = 1'b0;
        end
`endif
    end

    // Windows are decoded from the next counter so the registered outputs line up with it.
    always_comb begin
        run_d    = (state_d == RUN);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
        dc_rst_d = run_d && (cnt_d >= t1_d + CNT_W'(2)) && (cnt_d <= t1_d + n_ext_d + CNT_W'(8));
        dc_oe_d  = run_d && (cnt_d >= t1_d + CNT_W'(8)) && (cnt_d <= t1_d + n_ext_d + CNT_W'(7));
        ac_rst_d = run_d && (cnt_d >= t2_d + CNT_W'(2)) && (cnt_d <= ac_end_d + CNT_W'(8));
        ac_oe_d  = run_d && (cnt_d >= t2_d + CNT_W'(7)) && (cnt_d <= ac_end_d + CNT_W'(6));
        flush_d  = run_d && (cnt_d == ac_end_d + CNT_W'(7));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
            param_err_q <= 1'b0;
            dc_rst_q    <= 1'b0;
            dc_oe_q     <= 1'b0;
            ac_rst_q    <= 1'b0;
            ac_oe_q     <= 1'b0;
            flush_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            start_err_q <= start_err_d;
            param_err_q <= param_err_d;
            dc_rst_q    <= dc_rst_d;
            dc_oe_q     <= dc_oe_d;
            ac_rst_q    <= ac_rst_d;
            ac_oe_q     <= ac_oe_d;
            flush_q     <= flush_d;
        end
    end

`ifdef SEQ_START_QUEUE_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_q   <= 1'b0;
            pend_n_q <= '0;
        end else begin
            pend_q   <= pend_d;
            pend_n_q <= pend_n_d;
        end
    end
`endif

    assign bus.busy                 = busy_q;
    assign bus.done                 = done_q;
    assign bus.start_err            = start_err_q;
    assign bus.param_err            = param_err_q;
    assign bus.sequence_counter     = cnt_q;
    assign bus.dc_vlc_reset_n       = dc_rst_q;
    assign bus.dc_vlc_output_enable = dc_oe_q;
    assign bus.ac_vlc_reset_n       = ac_rst_q;
    assign bus.ac_vlc_output_enable = ac_oe_q;
    assign bus.ac_vlc_output_flush  = flush_q;
    // Stage counters read zero outside RUN so the reset state is all-zero.
    assign bus.dc_vlc_counter = (state_q == RUN) ? cnt_q - (t1_q + CNT_W'(1)) : '0;
    assign bus.ac_vlc_counter = (state_q == RUN) ? cnt_q - (t2_q + CNT_W'(1)) : '0;
endmodule

// File: tb/tb_slice_stage_sequencer.sv
// tb/tb_slice_stage_sequencer.sv - scoreboard bench for slice_stage_sequencer
module tb_slice_stage_sequencer;
    localparam int BLK_W = 8;
    localparam int CNT_W = 16;
    localparam int NK    = 12;
    localparam int K_DR_R = 0, K_DR_F = 1, K_DO_R = 2, K_DO_F = 3;
    localparam int K_AR_R = 4, K_AR_F = 5, K_AO_R = 6, K_AO_F = 7;
    localparam int K_FL = 8, K_DN = 9, K_SE = 10, K_PE = 11;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    slice_stage_sequencer_if #(.BLK_W(BLK_W), .CNT_W(CNT_W)) bus ();

    slice_stage_sequencer #(
        .DCT_LATENCY(12), .DC_VLC_LATENCY(44), .BLK_W(BLK_W), .MAX_BLOCKS(8), .CNT_W(CNT_W)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[NK][$];
    string kname[NK] = '{"dc_rst_rise", "dc_rst_fall", "dc_oe_rise", "dc_oe_fall",
                         "ac_rst_rise", "ac_rst_fall", "ac_oe_rise", "ac_oe_fall",
                         "flush", "done", "start_err", "param_err"};

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic push(input int k, input int c);
        exp_q[k].push_back(c);
    endtask

    task automatic observe(input int k, input int c);
        int e;
        n_tests++;
        if (exp_q[k].size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected event at c=%0d, expected none", kname[k], c);
        end else begin
            e = exp_q[k].pop_front();
            if (e >= 0 && e != c) begin
                n_fail++;
                $display("FAIL %s: got c=%0d expected c=%0d", kname[k], c, e);
            end
        end
    endtask

    // Hand-computed windows: N -> T1, T2, E with DCT=12, DCV=44.
    task automatic push_slice(input int n);
        case (n)
            1: begin
                push(K_DR_R, 15);  push(K_DR_F, 22);  push(K_DO_R, 21);  push(K_DO_F, 21);
                push(K_AR_R, 59);  push(K_AR_F, 128); push(K_AO_R, 64);  push(K_AO_F, 126);
                push(K_FL, 127);   push(K_DN, 128);
            end
            2: begin
                push(K_DR_R, 16);  push(K_DR_F, 24);  push(K_DO_R, 22);  push(K_DO_F, 23);
                push(K_AR_R, 60);  push(K_AR_F, 192); push(K_AO_R, 65);  push(K_AO_F, 190);
                push(K_FL, 191);   push(K_DN, 192);
            end
            4: begin
                push(K_DR_R, 18);  push(K_DR_F, 28);  push(K_DO_R, 24);  push(K_DO_F, 27);
                push(K_AR_R, 62);  push(K_AR_F, 320); push(K_AO_R, 67);  push(K_AO_F, 318);
                push(K_FL, 319);   push(K_DN, 320);
            end
            default: begin
                push(K_DR_R, 22);  push(K_DR_F, 36);  push(K_DO_R, 28);  push(K_DO_F, 35);
                push(K_AR_R, 66);  push(K_AR_F, 576); push(K_AO_R, 71);  push(K_AO_F, 574);
                push(K_FL, 575);   push(K_DN, 576);
            end
        endcase
    endtask

    logic p_dr = 1'b0, p_do = 1'b0, p_ar = 1'b0, p_ao = 1'b0;
    int   p_c = 0;
    int   mc;

    always @(negedge clock) begin
        if (!reset_n) begin
            p_dr = 1'b0; p_do = 1'b0; p_ar = 1'b0; p_ao = 1'b0; p_c = 0;
        end else begin
            mc = int'(bus.sequence_counter);
            if (bus.dc_vlc_reset_n && !p_dr) begin
                observe(K_DR_R, mc);
                check("dc_cnt_at_rst_rise", int'(bus.dc_vlc_counter), 1);
            end
            if (!bus.dc_vlc_reset_n && p_dr) observe(K_DR_F, p_c);
            if (bus.dc_vlc_output_enable && !p_do) begin
                observe(K_DO_R, mc);
                check("dc_cnt_at_oe_rise", int'(bus.dc_vlc_counter), 7);
            end
            if (!bus.dc_vlc_output_enable && p_do) observe(K_DO_F, p_c);
            if (bus.ac_vlc_reset_n && !p_ar) begin
                observe(K_AR_R, mc);
                check("ac_cnt_at_rst_rise", int'(bus.ac_vlc_counter), 1);
            end
            if (!bus.ac_vlc_reset_n && p_ar) observe(K_AR_F, p_c);
            if (bus.ac_vlc_output_enable && !p_ao) begin
                observe(K_AO_R, mc);
                check("ac_cnt_at_oe_rise", int'(bus.ac_vlc_counter), 6);
            end
            if (!bus.ac_vlc_output_enable && p_ao) observe(K_AO_F, p_c);
            if (bus.ac_vlc_output_flush) observe(K_FL, mc);
            if (bus.done)                observe(K_DN, mc);
            if (bus.start_err)           observe(K_SE, mc);
            if (bus.param_err)           observe(K_PE, mc);
            p_dr = bus.dc_vlc_reset_n;
            p_do = bus.dc_vlc_output_enable;
            p_ar = bus.ac_vlc_reset_n;
            p_ao = bus.ac_vlc_output_enable;
            p_c  = mc;
        end
    end

    task automatic start_slice(input int n, input bit chk);
        @(negedge clock);
        bus.slice_start = 1'b1;
        bus.block_num   = BLK_W'(n);
        @(negedge clock);
        bus.slice_start = 1'b0;
        if (chk) begin
            check("start_busy", int'(bus.busy), 1);
            check("start_counter", int'(bus.sequence_counter), 0);
        end
    endtask

    task automatic pulse_start(input int n);
        bus.slice_start = 1'b1;
        bus.block_num   = BLK_W'(n);
        @(negedge clock);
        bus.slice_start = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int i = 0;
        while (bus.busy && i < limit) begin
            @(negedge clock);
            i++;
        end
        check("idle_timeout", int'(bus.busy), 0);
    endtask

    task automatic wait_cnt(input int v, input int limit);
        int i = 0;
        while (int'(bus.sequence_counter) != v && i < limit) begin
            @(negedge clock);
            i++;
        end
        check("wait_counter", int'(bus.sequence_counter), v);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  int'(bus.busy), 0);
        check({tag, "_done"},  int'(bus.done), 0);
        check({tag, "_serr"},  int'(bus.start_err), 0);
        check({tag, "_perr"},  int'(bus.param_err), 0);
        check({tag, "_seq"},   int'(bus.sequence_counter), 0);
        check({tag, "_dcrst"}, int'(bus.dc_vlc_reset_n), 0);
        check({tag, "_dcoe"},  int'(bus.dc_vlc_output_enable), 0);
        check({tag, "_dccnt"}, int'(bus.dc_vlc_counter), 0);
        check({tag, "_acrst"}, int'(bus.ac_vlc_reset_n), 0);
        check({tag, "_acoe"},  int'(bus.ac_vlc_output_enable), 0);
        check({tag, "_flush"}, int'(bus.ac_vlc_output_flush), 0);
        check({tag, "_accnt"}, int'(bus.ac_vlc_counter), 0);
    endtask

    initial begin
        bus.slice_start = 1'b0;
        bus.block_num   = '0;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clock);
        check_all_zero("post_reset");

        push_slice(4);
        start_slice(4, 1'b1);
        wait_idle(1000);

        push_slice(1);
        start_slice(1, 1'b1);
        wait_idle(400);

        push_slice(8);
        start_slice(8, 1'b1);
        wait_idle(1000);

        push(K_PE, -1);
        start_slice(0, 1'b0);
        check("illegal0_busy", int'(bus.busy), 0);
        check("illegal0_perr", int'(bus.param_err), 1);
        push(K_PE, -1);
        start_slice(9, 1'b0);
        check("illegal9_busy", int'(bus.busy), 0);
        @(negedge clock);
        check("illegal9_still_idle", int'(bus.busy), 0);

`ifdef SEQ_START_QUEUE_EN
        push_slice(4);
        push_slice(2);
        start_slice(4, 1'b1);
        wait_cnt(100, 200);
        pulse_start(2);
        begin
            int i = 0;
            while (!bus.done && i < 400) begin
                @(negedge clock);
                i++;
            end
            check("queue_done_seen", int'(bus.done), 1);
        end
        @(negedge clock);
        check("queue_relaunch_busy", int'(bus.busy), 1);
        check("queue_relaunch_counter", int'(bus.sequence_counter), 0);
        wait_idle(400);
`else
        push_slice(4);
        push(K_SE, -1);
        start_slice(4, 1'b1);
        wait_cnt(100, 200);
        pulse_start(2);
        wait_idle(400);
        repeat (3) @(negedge clock);
        check("no_relaunch_busy", int'(bus.busy), 0);
`endif

        push_slice(4);
        start_slice(4, 1'b1);
        wait_cnt(150, 300);
        check("pre_reset_acrst", int'(bus.ac_vlc_reset_n), 1);
        #2 reset_n = 1'b0;
        #1 check_all_zero("mid_reset");
        for (int k = 0; k < NK; k++) exp_q[k].delete();
        @(negedge clock);
        #2 reset_n = 1'b1;
        push_slice(4);
        start_slice(4, 1'b1);
        wait_idle(1000);

        repeat (3) @(negedge clock);
        for (int k = 0; k < NK; k++) check({"leftover_", kname[k]}, exp_q[k].size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
